stopwatch_core: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 36 +++
 rtl/stopwatch_core_if.sv | 37 +++
 rtl/stopwatch_core_bcd_digit.sv | 44 ++++
 rtl/stopwatch_core.sv | 185 ++++++++++++++++++
 tb/tb_stopwatch_core.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared types and constants for the stopwatch_core slice:
//   state_t  - controller states (STOPPED / RUNNING)
//   BCD_W    - width of one BCD digit
//   DP_BIT   - bit position of the decimal point within the ssd byte
//   seg7()   - BCD digit to {g,f,e,d,c,b,a} segment pattern, active high
package stopwatch_pkg;

  typedef enum logic [0:0] {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  localparam int BCD_W  = 4;
  localparam int DP_BIT = 7;

  // Codes 10..15 never occur in a healthy count; they blank the digit.
  function automatic logic [6:0] seg7(input logic [BCD_W-1:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// stopwatch_core_if
// Groups the stopwatch control pulses and display/status outputs.
//   master: drives one/ten/pause/clear/lap pulses, observes outputs
//   slave : the stopwatch core itself
// Signals:
//   one_pulse, ten_pulse, pause_pulse, clear_pulse, lap_pulse - 1-cycle pulses
//   count_bcd [4*N_DIGITS] live count, digit i at [4i+3:4i]
//   ssd [8] {dp,g,f,e,d,c,b,a}; digit_sel [N_DIGITS] one-hot enable
//   running, rollover status
interface stopwatch_core_if
  import stopwatch_pkg::*;
#(
  parameter int N_DIGITS = 4
);

  logic                      one_pulse;
  logic                      ten_pulse;
  logic                      pause_pulse;
  logic                      clear_pulse;
  logic                      lap_pulse;
  logic [BCD_W*N_DIGITS-1:0] count_bcd;
  logic [7:0]                ssd;
  logic [N_DIGITS-1:0]       digit_sel;
  logic                      running;
  logic                      rollover;

  modport master (
    output one_pulse, ten_pulse, pause_pulse, clear_pulse, lap_pulse,
    input  count_bcd, ssd, digit_sel, running, rollover
  );

  modport slave (
    input  one_pulse, ten_pulse, pause_pulse, clear_pulse, lap_pulse,
    output count_bcd, ssd, digit_sel, running, rollover
  );

endinterface

// File: rtl/stopwatch_core_bcd_digit.sv
// bcd_digit
// One decade of the stopwatch counter (0..9 with carry out).
// Ports:
//   clk, n_rst    clock, asynchronous active-low reset
//   clr           synchronous zero
//   inc           +1 from the carry chain (or tick / one_pulse on digit 0)
//   inc_extra     independent second +1 in the same cycle; only the tens
//                 digit uses it, so one_pulse+ten_pulse adds 11 even when
//                 the ones digit carries at the same time
//   value         current digit
//   carry_out     combinational: this cycle's increment wraps the digit
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             inc_extra,
  output logic [BCD_W-1:0] value,
  output logic             carry_out
);

  logic [BCD_W:0] sum;

  // sum is at most 9+1+1 = 11, so a single carry always suffices.
  always_comb begin
    sum       = {1'b0, value} + (BCD_W+1)'(inc) + (BCD_W+1)'(inc_extra);
    carry_out = (sum >= (BCD_W+1)'(10));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (carry_out) begin
      value <= BCD_W'(sum - (BCD_W+1)'(10));
    end else begin
      value <= sum[BCD_W-1:0];
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core
// Stopwatch controller + N_DIGITS cascaded BCD counter + multiplexed
// seven-segment scan.
// Ports:
//   clk    system clock
//   n_rst  asynchronous active-low reset
//   bus    stopwatch_core_if.slave (control pulses in, count/display out)
// Parameters: N_DIGITS, TICK_DIV (clk per count), SCAN_DIV (clk per digit),
//   DP_POS (digit with lit decimal point).
// Optional feature: define STOPWATCH_LAP_EN to add a lap register that
//   freezes the display while counting continues.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int TICK_DIV = 100000,
  parameter int SCAN_DIV = 1000,
  parameter int DP_POS   = 2
) (
  input logic             clk,
  input logic             n_rst,
  stopwatch_core_if.slave bus
);

  localparam int COUNT_W = BCD_W * N_DIGITS;
  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = $clog2(N_DIGITS);

  localparam logic [0:0]         ST_STOPPED = STOPPED;
  localparam logic [0:0]         ST_RUNNING = RUNNING;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [IDX_W-1:0]   DP_IDX     = IDX_W'(DP_POS);

  logic [0:0]          state;
  logic [PRESC_W-1:0]  presc;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]    scan_idx;
  logic [COUNT_W-1:0]  count_live;
  logic [COUNT_W-1:0]  disp_count;
  logic [BCD_W-1:0]    scan_digit;
  logic [7:0]          seg_next;
  logic                is_running;
  logic                tick;
  logic                manual_ok;
  logic                man_one;
  logic                man_ten;
  logic                top_carry;
  logic                rollover_q;
  logic [7:0]          ssd_q;
  logic [N_DIGITS-1:0] digit_sel_q;

  // clear beats everything; pause suppresses manual increments but a tick
  // landing with pause is still counted before the state flips.
  assign is_running = (state == ST_RUNNING);
  assign tick       = is_running && (presc == PRESC_LAST) && !bus.clear_pulse;
  assign manual_ok  = !is_running && !bus.clear_pulse && !bus.pause_pulse;
  assign man_one    = manual_ok && bus.one_pulse;
  assign man_ten    = manual_ok && bus.ten_pulse;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_STOPPED;
    end else if (bus.clear_pulse) begin
      state <= ST_STOPPED;
    end else if (bus.pause_pulse) begin
      state <= is_running ? ST_STOPPED : ST_RUNNING;
    end
  end

  // Held while stopped so elapsed time is continuous across a pause.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      presc <= '0;
    end else if (bus.clear_pulse) begin
      presc <= '0;
    end else if (is_running) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + PRESC_W'(1);
    end
  end

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    logic             inc;
    logic             extra;
    logic             cout;
    logic [BCD_W-1:0] val;

    if (i == 0) begin : g_ones
      assign inc = tick || man_one;
    end else begin : g_upper
      assign inc = g_digit[i-1].cout;
    end

    assign extra = (i == 1) ? man_ten : 1'b0;

    bcd_digit u_digit (
      .clk       (clk),
      .n_rst     (n_rst),
      .clr       (bus.clear_pulse),
      .inc       (inc),
      .inc_extra (extra),
      .value     (val),
      .carry_out (cout)
    );

    assign count_live[BCD_W*i +: BCD_W] = val;
  end

  assign top_carry = g_digit[N_DIGITS-1].cout;

  // The digits wrap to zero on their own; this only flags the event.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rollover_q <= 1'b0;
    end else begin
      rollover_q <= top_carry;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic               lap_hold;
  logic [COUNT_W-1:0] lap_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lap_hold  <= 1'b0;
      lap_count <= '0;
    end else if (bus.clear_pulse) begin
      lap_hold  <= 1'b0;
    end else if (bus.lap_pulse) begin
      if (lap_hold) begin
        lap_hold  <= 1'b0;
      end else if (is_running) begin
        lap_hold  <= 1'b1;
        lap_count <= count_live;
      end
    end
  end

  assign disp_count = lap_hold ? lap_count : count_live;
`else
  logic unused_lap;
  assign unused_lap = bus.lap_pulse;
  assign disp_count = count_live;
`endif

  // Scan runs in every state so the display never freezes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  always_comb begin
    scan_digit       = disp_count[BCD_W*scan_idx +: BCD_W];
    seg_next         = {1'b0, seg7(scan_digit)};
    seg_next[DP_BIT] = (scan_idx == DP_IDX);
  end

  // Registered so segments and enable change together, glitch-free.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ssd_q       <= '0;
      digit_sel_q <= '0;
    end else begin
      ssd_q       <= seg_next;
      digit_sel_q <= N_DIGITS'(1) << scan_idx;
    end
  end

  assign bus.count_bcd = count_live;
  assign bus.running   = is_running;
  assign bus.rollover  = rollover_q;
  assign bus.ssd       = ssd_q;
  assign bus.digit_sel = digit_sel_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core
// Directed bench for stopwatch_core (N_DIGITS=4, TICK_DIV=4, SCAN_DIV=2,
// DP_POS=2). A decimal reference model predicts every output each cycle;
// predictions go into a scoreboard queue and are compared after the edge.
// Honours STOPWATCH_LAP_EN the same way the design does.
module tb_stopwatch_core;
  import stopwatch_pkg::*;

  localparam int ND  = 4;
  localparam int TD  = 4;
  localparam int SD  = 2;
  localparam int DP  = 2;
  localparam int MOD = 10000;

  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct {
    logic [15:0]   count;
    logic          run;
    logic          roll;
    logic [7:0]    ssd;
    logic [ND-1:0] sel;
  } exp_t;

  logic clk;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  int m_val;
  bit m_run;
  int m_presc;
  bit m_roll;
  int m_scan_cnt;
  int m_idx;
  bit m_lap_hold;
  int m_lap_val;

  stopwatch_core_if #(.N_DIGITS(ND)) bus ();

  stopwatch_core #(
    .N_DIGITS (ND),
    .TICK_DIV (TD),
    .SCAN_DIV (SD),
    .DP_POS   (DP)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int dec_digit(int v, int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'(dec_digit(v, i));
    return r;
  endfunction

  // Expected ssd for count 1234, keyed by the enabled digit.
  function automatic logic [7:0] scan_expect(logic [ND-1:0] sel);
    case (sel)
      4'b0001: return 8'h66;
      4'b0010: return 8'h4F;
      4'b0100: return 8'hDB;
      4'b1000: return 8'h06;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    e = sb_q.pop_front();
    checkValue("count_bcd", 32'(bus.count_bcd), 32'(e.count));
    checkValue("running",   32'(bus.running),   32'(e.run));
    checkValue("rollover",  32'(bus.rollover),  32'(e.roll));
    checkValue("ssd",       32'(bus.ssd),       32'(e.ssd));
    checkValue("digit_sel", 32'(bus.digit_sel), 32'(e.sel));
  endtask

  task automatic resetModel();
    m_val = 0; m_run = 0; m_presc = 0; m_roll = 0;
    m_scan_cnt = 0; m_idx = 0; m_lap_hold = 0; m_lap_val = 0;
    sb_q.delete();
  endtask

  // Drive one cycle of pulses, predict the post-edge outputs, then check.
  task automatic applyStimulus(input bit one, input bit ten, input bit pause,
                               input bit clr, input bit lap);
    exp_t e;
    int   disp;
    int   add;
    bus.one_pulse   = one;
    bus.ten_pulse   = ten;
    bus.pause_pulse = pause;
    bus.clear_pulse = clr;
    bus.lap_pulse   = lap;

    disp = m_val;
`ifdef STOPWATCH_LAP_EN
    if (m_lap_hold) disp = m_lap_val;
    if (clr) m_lap_hold = 0;
    else if (lap) begin
      if (m_lap_hold) m_lap_hold = 0;
      else if (m_run) begin
        m_lap_hold = 1;
        m_lap_val  = m_val;
      end
    end
`endif
    e.sel = ND'(1) << m_idx;
    e.ssd = {(m_idx == DP), SEG_TAB[dec_digit(disp, m_idx)]};
    if (m_scan_cnt == SD - 1) begin
      m_scan_cnt = 0;
      m_idx = (m_idx + 1) % ND;
    end else begin
      m_scan_cnt++;
    end

    add = 0;
    m_roll = 0;
    if (clr) begin
      m_val = 0; m_presc = 0; m_run = 0;
    end else begin
      if (m_run) begin
        if (m_presc == TD - 1) begin
          m_presc = 0;
          add = 1;
        end else begin
          m_presc++;
        end
      end else if (!pause) begin
        add = (one ? 1 : 0) + (ten ? 10 : 0);
      end
      if (m_val + add >= MOD) m_roll = 1;
      m_val = (m_val + add) % MOD;
      if (pause) m_run = !m_run;
    end
    e.count = to_bcd(m_val);
    e.run   = m_run;
    e.roll  = m_roll;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    bus.one_pulse   = 1'b0;
    bus.ten_pulse   = 1'b0;
    bus.pause_pulse = 1'b0;
    bus.clear_pulse = 1'b0;
    bus.lap_pulse   = 1'b0;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic checkResetState(input string tag);
    checkValue({tag, "_count"}, 32'(bus.count_bcd), 32'h0);
    checkValue({tag, "_run"},   32'(bus.running),   32'h0);
    checkValue({tag, "_roll"},  32'(bus.rollover),  32'h0);
    checkValue({tag, "_ssd"},   32'(bus.ssd),       32'h0);
    checkValue({tag, "_sel"},   32'(bus.digit_sel), 32'h0);
  endtask

  initial begin
    n_rst = 1'b0;
    bus.one_pulse = 1'b0; bus.ten_pulse = 1'b0; bus.pause_pulse = 1'b0;
    bus.clear_pulse = 1'b0; bus.lap_pulse = 1'b0;
    resetModel();
    #12;
    checkResetState("reset");
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    $display("[TB] run 10 ticks");
    applyStimulus(0, 0, 1, 0, 0);
    idle(40);
    checkValue("run40_count", 32'(bus.count_bcd), 32'h0010);
    checkValue("run40_running", 32'(bus.running), 32'h1);

    $display("[TB] manual increments");
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    for (int k = 0; k < 9; k++) applyStimulus(1, 0, 0, 0, 0);
    checkValue("ones_0009", 32'(bus.count_bcd), 32'h0009);
    applyStimulus(1, 0, 0, 0, 0);
    checkValue("ones_0010", 32'(bus.count_bcd), 32'h0010);
    applyStimulus(0, 0, 0, 1, 0);
    for (int k = 0; k < 9; k++) applyStimulus(0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) applyStimulus(1, 0, 0, 0, 0);
    checkValue("pre_0095", 32'(bus.count_bcd), 32'h0095);
    applyStimulus(0, 1, 0, 0, 0);
    checkValue("tens_0105", 32'(bus.count_bcd), 32'h0105);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkValue("both_0011", 32'(bus.count_bcd), 32'h0011);

    $display("[TB] one_pulse ignored while running");
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkValue("run_one_ignored", 32'(bus.count_bcd), 32'h0000);
    idle(3);
    checkValue("run_tick_0001", 32'(bus.count_bcd), 32'h0001);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);

    $display("[TB] rollover");
    applyStimulus(0, 0, 0, 1, 0);
    for (int k = 0; k < 9; k++) applyStimulus(1, 0, 0, 0, 0);
    for (int k = 0; k < 999; k++) applyStimulus(0, 1, 0, 0, 0);
    checkValue("preload_9999", 32'(bus.count_bcd), 32'h9999);
    applyStimulus(0, 0, 1, 0, 0);
    idle(3);
    checkValue("pre_wrap_count", 32'(bus.count_bcd), 32'h9999);
    checkValue("pre_wrap_roll", 32'(bus.rollover), 32'h0);
    idle(1);
    checkValue("wrap_count", 32'(bus.count_bcd), 32'h0000);
    checkValue("wrap_roll", 32'(bus.rollover), 32'h1);
    idle(1);
    checkValue("post_wrap_roll", 32'(bus.rollover), 32'h0);

    $display("[TB] pause keeps prescaler");
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    idle(1);
    applyStimulus(0, 0, 1, 0, 0);
    idle(20);
    checkValue("paused_running", 32'(bus.running), 32'h0);
    applyStimulus(0, 0, 1, 0, 0);
    idle(1);
    checkValue("resume_1cyc", 32'(bus.count_bcd), 32'h0000);
    idle(1);
    checkValue("resume_2cyc", 32'(bus.count_bcd), 32'h0001);
    applyStimulus(0, 0, 1, 1, 0);
    checkValue("clr_pause_count", 32'(bus.count_bcd), 32'h0000);
    checkValue("clr_pause_run", 32'(bus.running), 32'h0);

    $display("[TB] display scan at 1234");
    for (int k = 0; k < 123; k++) applyStimulus(0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 0, 0);
    checkValue("preload_1234", 32'(bus.count_bcd), 32'h1234);
    for (int k = 0; k < 8; k++) begin
      idle(1);
      checkValue("scan_ssd", 32'(bus.ssd), 32'(scan_expect(bus.digit_sel)));
    end

    $display("[TB] lap");
    applyStimulus(0, 0, 0, 1, 0);
    for (int k = 0; k < 7; k++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      idle(1);
`ifdef STOPWATCH_LAP_EN
      if (bus.digit_sel == 4'b0001)
        checkValue("lap_frozen_ssd", 32'(bus.ssd), 32'h07);
`endif
    end
    checkValue("lap_live_count", 32'(bus.count_bcd), 32'h0012);
    applyStimulus(0, 0, 0, 0, 1);
    idle(4);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkValue("lap_clr_count", 32'(bus.count_bcd), 32'h0000);
    checkValue("lap_clr_run", 32'(bus.running), 32'h0);
    for (int k = 0; k < 8; k++) begin
      idle(1);
      if (bus.digit_sel == 4'b0001)
        checkValue("lap_clr_ssd", 32'(bus.ssd), 32'h3F);
    end

    $display("[TB] reset mid-operation");
    applyStimulus(0, 0, 1, 0, 0);
    idle(5);
    n_rst = 1'b0;
    #2;
    checkResetState("midreset");
    resetModel();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
